// File: rtl/mfm_sync_decoder.sv
// MFM cell-stream decoder with address-mark synchronisation.
// Qualified cells shift into a 2*DATA_BITS window. The decoder slides over
// the stream until it sees the sync pattern. It then checks that
// SYNC_MARKS-1 further marks follow back to back. After that it frames every
// W cells as one data word and flags words that break the MFM clock rule.
module mfm_sync_decoder #(
    parameter int                       DATA_BITS    = 8,
    parameter logic [2*DATA_BITS-1:0]   SYNC_PATTERN = 16'h4489,
    parameter int                       SYNC_MARKS   = 3,
    parameter int                       DATA_PHASE   = 0,
    parameter int                       ERR_LIMIT    = 4
) (
    input  logic                     clk_5,
    input  logic                     reset_n,
    input  logic                     raw_mfm,
    input  logic                     cell_en,
    input  logic                     hunt,
    output logic [2*DATA_BITS-1:0]   mfm_buffer,
    output logic [DATA_BITS-1:0]     byte_out,
    output logic                     byte_valid,
    output logic                     sync_found,
    output logic                     in_sync,
    output logic                     clock_err
);

    localparam int W  = 2 * DATA_BITS;
    localparam int CW = $clog2(W);
    localparam int EW = (ERR_LIMIT > 0) ? $clog2(ERR_LIMIT + 1) : 1;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_MARK = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [W-1:0]          buf_q, buf_d;
    logic [DATA_BITS-1:0]  byte_q, byte_d;
    logic                  byte_valid_q, byte_valid_d;
    logic                  sync_found_q, sync_found_d;
    logic                  clock_err_q, clock_err_d;
    logic                  in_sync_q, in_sync_d;
    logic [CW-1:0]         cell_cnt_q, cell_cnt_d;
    logic [2:0]            mark_cnt_q, mark_cnt_d;
    logic [EW-1:0]         err_cnt_q, err_cnt_d;
    logic                  prev_d_q, prev_d_d;
    logic [W-1:0]          nb_s;
    logic                  boundary_s;

    // Pick the data cells out of a window, first-received cell becomes the MSB.
    function automatic logic [DATA_BITS-1:0] decode_word(input logic [W-1:0] cells);
        logic [DATA_BITS-1:0] w;
        w = '0;
        for (int i = 0; i < DATA_BITS; i++) begin
            w[DATA_BITS-1-i] = cells[W-2-2*i+DATA_PHASE];
        end
        return w;
    endfunction

    // A clock cell must equal NOR of its two neighbouring data cells.
    // In even phase the leading clock borrows the last data cell of the
    // previous word (prev_d). In odd phase only the interior clocks are
    // bounded by data cells on both sides.
    function automatic logic clock_rule_err(input logic [W-1:0] cells, input logic prev_d);
        logic [W:0] ext;
        logic       err;
        ext = {prev_d, cells};
        err = 1'b0;
        if (DATA_PHASE == 0) begin
            for (int i = 0; i < DATA_BITS; i++) begin
                err = err | (ext[W-1-2*i] != ~(ext[W-2*i] | ext[W-2-2*i]));
            end
        end else begin
            for (int i = 0; i < DATA_BITS - 1; i++) begin
                err = err | (ext[W-2-2*i] != ~(ext[W-1-2*i] | ext[W-3-2*i]));
            end
        end
        return err;
    endfunction

    // Next-state logic: window shift, word framing, mark hunting and error counting.
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        sync_found_d = 1'b0;
        clock_err_d  = 1'b0;
        cell_cnt_d   = cell_cnt_q;
        mark_cnt_d   = mark_cnt_q;
        err_cnt_d    = err_cnt_q;
        prev_d_d     = prev_d_q;
        nb_s         = cell_en ? {buf_q[W-2:0], raw_mfm} : buf_q;
        boundary_s   = cell_en && (cell_cnt_q == CW'(W - 1));

        if (cell_en) begin
            buf_d      = nb_s;
            cell_cnt_d = boundary_s ? '0 : cell_cnt_q + CW'(1);
        end else begin
            buf_d      = buf_q;
        end

        if (hunt) begin
            // Re-hunt wins over any word boundary in the same cycle.
            state_d    = ST_HUNT;
            cell_cnt_d = '0;
            mark_cnt_d = '0;
            err_cnt_d  = '0;
        end else if (cell_en) begin
            case (state_q)
                ST_HUNT: begin
                    if (nb_s == SYNC_PATTERN) begin
                        mark_cnt_d = 3'd1;
                        cell_cnt_d = '0;
                        prev_d_d   = nb_s[DATA_PHASE];
                        if (SYNC_MARKS == 1) begin
                            state_d      = ST_DATA;
                            sync_found_d = 1'b1;
                            byte_d       = decode_word(nb_s);
                            err_cnt_d    = '0;
                        end else begin
                            state_d      = ST_MARK;
                        end
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_MARK: begin
                    if (boundary_s) begin
                        if (nb_s == SYNC_PATTERN) begin
                            mark_cnt_d = mark_cnt_q + 3'd1;
                            prev_d_d   = nb_s[DATA_PHASE];
                            if ((mark_cnt_q + 3'd1) == 3'(SYNC_MARKS)) begin
                                state_d      = ST_DATA;
                                sync_found_d = 1'b1;
                                byte_d       = decode_word(nb_s);
                                err_cnt_d    = '0;
                            end else begin
                                state_d      = ST_MARK;
                            end
                        end else begin
                            // Broken run: fall back to sliding search from the next cell.
                            state_d    = ST_HUNT;
                            mark_cnt_d = '0;
                        end
                    end else begin
                        state_d = ST_MARK;
                    end
                end
                ST_DATA: begin
                    if (boundary_s) begin
                        byte_d       = decode_word(nb_s);
                        byte_valid_d = 1'b1;
                        clock_err_d  = clock_rule_err(nb_s, prev_d_q);
                        prev_d_d     = nb_s[DATA_PHASE];
                        if (clock_err_d && (ERR_LIMIT != 0)) begin
                            if ((int'(err_cnt_q) + 1) >= ERR_LIMIT) begin
                                state_d    = ST_HUNT;
                                err_cnt_d  = '0;
                                mark_cnt_d = '0;
                            end else begin
                                err_cnt_d  = err_cnt_q + EW'(1);
                            end
                        end else begin
                            err_cnt_d = '0;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                default: begin
                    state_d    = ST_HUNT;
                    mark_cnt_d = '0;
                    err_cnt_d  = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        in_sync_d = (state_d == ST_DATA);
    end

    // State and output registers, cleared asynchronously by reset_n.
    always_ff @(posedge clk_5 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_HUNT;
            buf_q        <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            sync_found_q <= 1'b0;
            clock_err_q  <= 1'b0;
            in_sync_q    <= 1'b0;
            cell_cnt_q   <= '0;
            mark_cnt_q   <= '0;
            err_cnt_q    <= '0;
            prev_d_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            sync_found_q <= sync_found_d;
            clock_err_q  <= clock_err_d;
            in_sync_q    <= in_sync_d;
            cell_cnt_q   <= cell_cnt_d;
            mark_cnt_q   <= mark_cnt_d;
            err_cnt_q    <= err_cnt_d;
            prev_d_q     <= prev_d_d;
        end
    end

    assign mfm_buffer = buf_q;
    assign byte_out   = byte_q;
    assign byte_valid = byte_valid_q;
    assign sync_found = sync_found_q;
    assign in_sync    = in_sync_q;
    assign clock_err  = clock_err_q;

endmodule

// File: tb/tb_mfm_sync_decoder.sv
// Directed bench for mfm_sync_decoder: default build plus a
// DATA_BITS=4 / SYNC_MARKS=1 / DATA_PHASE=1 build.
module tb_mfm_sync_decoder;

    logic        clk_5 = 1'b0;
    logic        reset_n;
    logic        raw_s, en_s, hunt_s;
    logic [15:0] buf_s;
    logic [7:0]  byte_s;
    logic        bv_s, sf_s, ins_s, ce_s;
    logic        raw_v_s, en_v_s, hunt_v_s;
    logic [7:0]  buf_v_s;
    logic [3:0]  byte_v_s;
    logic        bv_v_s, sf_v_s, ins_v_s, ce_v_s;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] word;
        logic        gap;
        logic        exp_sf;
        logic        exp_bv;
        logic [7:0]  exp_byte;
        logic        exp_ce;
        logic        exp_in;
    } vec_t;

    vec_t tbl [21];

    // Cell clock
    always #5 clk_5 = ~clk_5;

    mfm_sync_decoder dut (
        .clk_5(clk_5), .reset_n(reset_n), .raw_mfm(raw_s), .cell_en(en_s), .hunt(hunt_s),
        .mfm_buffer(buf_s), .byte_out(byte_s), .byte_valid(bv_s), .sync_found(sf_s),
        .in_sync(ins_s), .clock_err(ce_s)
    );

    mfm_sync_decoder #(
        .DATA_BITS(4), .SYNC_PATTERN(8'h89), .SYNC_MARKS(1), .DATA_PHASE(1), .ERR_LIMIT(4)
    ) dut_v (
        .clk_5(clk_5), .reset_n(reset_n), .raw_mfm(raw_v_s), .cell_en(en_v_s), .hunt(hunt_v_s),
        .mfm_buffer(buf_v_s), .byte_out(byte_v_s), .byte_valid(bv_v_s), .sync_found(sf_v_s),
        .in_sync(ins_v_s), .clock_err(ce_v_s)
    );

    function automatic vec_t mkv(input logic [15:0] w, input logic g, input logic sf,
                                 input logic bv, input logic [7:0] b, input logic ce,
                                 input logic ins);
        vec_t r;
        r.word = w; r.gap = g; r.exp_sf = sf; r.exp_bv = bv;
        r.exp_byte = b; r.exp_ce = ce; r.exp_in = ins;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_5);
            #1;
        end
    endtask

    task automatic drive_cell(input bit sel, input logic v, input logic h);
        @(negedge clk_5);
        if (sel) begin
            raw_v_s = v; en_v_s = 1'b1; hunt_v_s = h;
        end else begin
            raw_s = v; en_s = 1'b1; hunt_s = h;
        end
        @(posedge clk_5);
        #1;
        en_s = 1'b0; hunt_s = 1'b0; en_v_s = 1'b0; hunt_v_s = 1'b0;
    endtask

    // Send nbits cells of w MSB-first; no strobe may appear before the last cell.
    task automatic send_word(input bit sel, input logic [15:0] w, input int nbits,
                             input bit gaps, input bit hunt_last);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (gaps) idle(int'($urandom_range(0, 2)));
            drive_cell(sel, w[i], hunt_last && (i == 0));
            if (i != 0) begin
                if (sel) chk("no_early_strobe_v", 32'({sf_v_s, bv_v_s}), 32'd0);
                else     chk("no_early_strobe", 32'({sf_s, bv_s}), 32'd0);
            end
        end
    endtask

    task automatic apply_row(input int idx, input vec_t r);
        send_word(1'b0, r.word, 16, r.gap, 1'b0);
        chk($sformatf("row%0d_sync_found", idx), 32'(sf_s), 32'(r.exp_sf));
        chk($sformatf("row%0d_byte_valid", idx), 32'(bv_s), 32'(r.exp_bv));
        chk($sformatf("row%0d_byte_out", idx), 32'(byte_s), 32'(r.exp_byte));
        chk($sformatf("row%0d_clock_err", idx), 32'(ce_s), 32'(r.exp_ce));
        chk($sformatf("row%0d_in_sync", idx), 32'(ins_s), 32'(r.exp_in));
        chk($sformatf("row%0d_mfm_buffer", idx), 32'(buf_s), 32'(r.word));
        if (r.gap) begin
            idle(1);
            chk($sformatf("row%0d_strobe_len", idx), 32'({sf_s, bv_s}), 32'd0);
        end
    endtask

    // Guard against a stuck run
    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // Main stimulus
    initial begin
        //              word     gap  sf  bv  byte   ce  in
        tbl[0]  = mkv(16'h4489, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[1]  = mkv(16'h4489, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[2]  = mkv(16'h4489, 1'b0, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b1);
        tbl[3]  = mkv(16'h5554, 1'b0, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b1);
        tbl[4]  = mkv(16'h7555, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
        tbl[5]  = mkv(16'h7555, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
        tbl[6]  = mkv(16'h5555, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
        tbl[7]  = mkv(16'h7555, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
        tbl[8]  = mkv(16'h7555, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
        tbl[9]  = mkv(16'h7555, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
        tbl[10] = mkv(16'h7555, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
        tbl[11] = mkv(16'h4489, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
        tbl[12] = mkv(16'h4489, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
        tbl[13] = mkv(16'h5555, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
        tbl[14] = mkv(16'h4489, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
        tbl[15] = mkv(16'h4489, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
        tbl[16] = mkv(16'h4489, 1'b0, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b1);
        tbl[17] = mkv(16'h4489, 1'b1, 1'b0, 1'b0, 8'hA1, 1'b0, 1'b0);
        tbl[18] = mkv(16'h4489, 1'b1, 1'b0, 1'b0, 8'hA1, 1'b0, 1'b0);
        tbl[19] = mkv(16'h4489, 1'b1, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b1);
        tbl[20] = mkv(16'h5554, 1'b1, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b1);

        reset_n = 1'b0;
        raw_s = 1'b0; en_s = 1'b0; hunt_s = 1'b0;
        raw_v_s = 1'b0; en_v_s = 1'b0; hunt_v_s = 1'b0;
        #2;
        chk("rst_mfm_buffer", 32'(buf_s), 32'd0);
        chk("rst_byte_out", 32'(byte_s), 32'd0);
        chk("rst_strobes", 32'({sf_s, bv_s, ce_s}), 32'd0);
        chk("rst_in_sync", 32'(ins_s), 32'd0);
        @(negedge clk_5);
        reset_n = 1'b1;

        // Sync/decode, clock errors, broken mark run, resync
        for (int i = 0; i <= 16; i++) apply_row(i, tbl[i]);

        // hunt on the last cell of a data word suppresses its strobe
        send_word(1'b0, 16'h5554, 16, 1'b0, 1'b1);
        chk("hunt_byte_valid", 32'(bv_s), 32'd0);
        chk("hunt_sync_found", 32'(sf_s), 32'd0);
        chk("hunt_in_sync", 32'(ins_s), 32'd0);
        chk("hunt_byte_out", 32'(byte_s), 32'hA1);
        chk("hunt_mfm_buffer", 32'(buf_s), 32'h5554);

        // Gapped repeat of the basic sync and decode sequence
        for (int i = 17; i <= 20; i++) apply_row(i, tbl[i]);

        // Reset in the middle of a word
        send_word(1'b0, 16'h0055, 8, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_mfm_buffer", 32'(buf_s), 32'd0);
        chk("midrst_byte_out", 32'(byte_s), 32'd0);
        chk("midrst_strobes", 32'({sf_s, bv_s, ce_s}), 32'd0);
        chk("midrst_in_sync", 32'(ins_s), 32'd0);
        @(negedge clk_5);
        reset_n = 1'b1;
        send_word(1'b0, 16'h5554, 16, 1'b0, 1'b0);
        chk("postrst_byte_valid", 32'(bv_s), 32'd0);
        chk("postrst_in_sync", 32'(ins_s), 32'd0);
        chk("postrst_mfm_buffer", 32'(buf_s), 32'h5554);

        // Variant: single 8-cell mark, odd data phase
        send_word(1'b1, 16'h0089, 8, 1'b0, 1'b0);
        chk("v_sync_found", 32'(sf_v_s), 32'd1);
        chk("v_mark_byte", 32'(byte_v_s), 32'hA);
        chk("v_in_sync", 32'(ins_v_s), 32'd1);
        chk("v_mark_bv", 32'(bv_v_s), 32'd0);
        send_word(1'b1, 16'h004A, 8, 1'b0, 1'b0);
        chk("v_w1_byte_valid", 32'(bv_v_s), 32'd1);
        chk("v_w1_byte_out", 32'(byte_v_s), 32'h3);
        chk("v_w1_clock_err", 32'(ce_v_s), 32'd0);
        chk("v_w1_buffer", 32'(buf_v_s), 32'h4A);
        send_word(1'b1, 16'h004E, 8, 1'b0, 1'b0);
        chk("v_w2_byte_valid", 32'(bv_v_s), 32'd1);
        chk("v_w2_byte_out", 32'(byte_v_s), 32'h3);
        chk("v_w2_clock_err", 32'(ce_v_s), 32'd1);
        chk("v_w2_in_sync", 32'(ins_v_s), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mfm_sync_decoder.md
Name: mfm_sync_decoder

Overview:
- Parametrised MFM cell-stream decoder with address-mark synchronisation.
- Shifts qualified MFM cells into a 2*DATA_BITS window and hunts for SYNC_MARKS consecutive sync patterns.
- Once synchronised, emits framed decoded words with a valid strobe and an MFM clock-rule error flag.
- Sits between the data separator (cell recovery) and the sector/header parser.

Parameters:
- DATA_BITS, 8: decoded bits per word; window W = 2*DATA_BITS cells.
- SYNC_PATTERN, 16'h4489: W-bit raw cell pattern of the address mark (missing-clock A1).
- SYNC_MARKS, 3: consecutive back-to-back marks required before data framing; range 1..7.
- DATA_PHASE, 0: 0 = data cells at even window positions (w[W-2]..w[0]); 1 = odd positions (w[W-1]..w[1]).
- ERR_LIMIT, 4: consecutive clock-error words that force a return to HUNT; 0 disables the drop.

Ports:
- clk_5  input  1  cell clock, rising edge only
- reset_n  input  1  asynchronous active-low reset
- raw_mfm  input  1  recovered MFM cell value
- cell_en  input  1  raw_mfm is a valid cell this cycle
- hunt  input  1  synchronous request to abandon framing and re-hunt
- mfm_buffer  output  W  raw cell window; newest cell in bit 0
- byte_out  output  DATA_BITS  decoded word; data cells MSB-first
- byte_valid  output  1  one-cycle strobe, byte_out is a data word
- sync_found  output  1  one-cycle strobe, final required mark seen; byte_out holds the decoded mark
- in_sync  output  1  high while in DATA state
- clock_err  output  1  qualifies byte_valid; the word violates the MFM clock rule

Behaviour:
- Reset (async, reset_n=0): every register clears. mfm_buffer=0, byte_out=0, byte_valid=0, sync_found=0, in_sync=0, clock_err=0, state=HUNT, all counters 0.
- Shift: on posedge clk_5 with cell_en=1, mfm_buffer <= {mfm_buffer[W-2:0], raw_mfm}. When cell_en=0, nothing advances. Let nb denote the post-shift value.
- Decode: byte_out takes the DATA_PHASE-selected cells of nb, MSB-first.
- Strobes: every strobe and flag is registered and asserted in the cycle after the clock edge that accepted the completing cell. Strobes last exactly one cycle.
- States: HUNT, MARK, DATA. cell_cnt counts accepted cells 0..W-1 and marks a word boundary when it wraps.
- HUNT:
  - Cells are compared every accepted cycle (sliding window).
  - On nb==SYNC_PATTERN: mark_cnt=1 and cell_cnt=0.
  - If SYNC_MARKS=1: go to DATA and pulse sync_found. Otherwise go to MARK.
- MARK: at each word boundary, compare nb with SYNC_PATTERN.
  - Match: mark_cnt++. When mark_cnt reaches SYNC_MARKS, go to DATA and pulse sync_found.
  - Mismatch: go to HUNT.
  - A mismatch does not itself restart matching; sliding comparison resumes on the next cell.
- DATA (in_sync=1):
  - At each word boundary, latch byte_out and pulse byte_valid.
  - clock_err=1 if any checked clock cell c ≠ NOR(adjacent data cells).
  - DATA_PHASE=0: all DATA_BITS clock cells are checked. The leading clock uses prev_d, the last data cell of the previous word or mark.
  - DATA_PHASE=1: only the DATA_BITS-1 interior clocks are checked.
  - Error counting: err_cnt++ on each word with clock_err, and clears on a clean word. When err_cnt reaches ERR_LIMIT (if ERR_LIMIT≠0), go to HUNT after that word's strobe.
  - A sync pattern seen in DATA is decoded as data; no resync occurs.
- hunt=1 (any state):
  - Next state is HUNT; counters clear; in_sync=0 next cycle; no strobe that cycle.
  - The shift in the same cycle still occurs.
  - hunt has priority over a simultaneous word boundary.
- Counter widths: cell_cnt ceil(log2(W)), mark_cnt 3 bits, err_cnt ceil(log2(ERR_LIMIT+1)) (min 1).
- Reset mid-word: any partial word is discarded and no strobe is issued.

Test Plan:
- Reset: reset_n=0 mid-stream -> all outputs 0 immediately, without waiting for clk_5; state=HUNT.
- Basic sync and decode:
  - Stimulus: defaults, cell_en=1; feed 4489,4489,4489 then MFM of 0xFE (cells 5554 with prev_d=1).
  - Required: sync_found pulses with byte_out=A1, 1 cycle after cell 48.
  - Then byte_valid=1, byte_out=FE, clock_err=0 after cell 64.
  - in_sync rises with sync_found.
- Broken mark run: 4489,4489,5555 -> no sync_found; state returns to HUNT. A following 3×4489 then syncs normally.
- Gapped cells: insert random cell_en=0 cycles inside the sequence from scenario 2 -> identical byte_out values and strobe order; strobes land 1 cycle after the completing enabled edge.
- Clock errors:
  - Stimulus: after sync, words with a forced bad clock cell (0x5555 with bit 13 set, i.e. 0x7555).
  - Required: each strobe has clock_err=1. On the 4th consecutive error in_sync drops the next cycle.
  - A clean word between errors resets err_cnt.
- hunt and parameter variants:
  - hunt=1 coincident with the 16th cell of a data word -> no byte_valid; in_sync=0.
  - Repeat scenario 2 with SYNC_MARKS=1, DATA_BITS=4 (pattern 8'h89) and DATA_PHASE=1 -> byte_out equals the odd-position cells.
